// File: rtl/rmw_pkg.sv
// Shared types and constants for the 6502 read-modify-write sequencer.
package rmw_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_DWR,
    S_MOD,
    S_WR,
    S_FIN
  } state_t;

  localparam logic [2:0] OP_ASL = 3'b000;
  localparam logic [2:0] OP_LSR = 3'b001;
  localparam logic [2:0] OP_ROL = 3'b010;
  localparam logic [2:0] OP_ROR = 3'b011;
  localparam logic [2:0] OP_INC = 3'b100;
  localparam logic [2:0] OP_DEC = 3'b101;

  localparam logic [4:0] SEL_PASS_M = 5'b01101;
  localparam logic [4:0] SEL_ASL_M  = 5'b10000;
  localparam logic [4:0] SEL_LSR_M  = 5'b00110;
  localparam logic [4:0] SEL_ROL_M  = 5'b01000;
  localparam logic [4:0] SEL_ROR_M  = 5'b01010;
  localparam logic [4:0] SEL_INC_M  = 5'b10011;
  localparam logic [4:0] SEL_DEC_M  = 5'b10110;

  function automatic logic [4:0] op_to_sel(input logic [2:0] op);
    case (op)
      OP_ASL:  return SEL_ASL_M;
      OP_LSR:  return SEL_LSR_M;
      OP_ROL:  return SEL_ROL_M;
      OP_ROR:  return SEL_ROR_M;
      OP_INC:  return SEL_INC_M;
      OP_DEC:  return SEL_DEC_M;
      default: return SEL_PASS_M;
    endcase
  endfunction

  function automatic logic op_legal(input logic [2:0] op);
    return op <= OP_DEC;
  endfunction

endpackage

// File: rtl/rmw_flags.sv
// Combinational N/Z/C for a read-modify-write result; C is 0 for INC/DEC.
module rmw_flags
  import rmw_pkg::*;
(
  input  logic [2:0] op,
  input  logic [7:0] operand,
  input  logic [7:0] result,
  output logic       n,
  output logic       z,
  output logic       c
);

  always_comb begin
    n = result[7];
    z = (result == 8'h00);
    c = 1'b0;
    case (op)
      OP_ASL, OP_ROL: c = operand[7];
      OP_LSR, OP_ROR: c = operand[0];
      default:        c = 1'b0;
    endcase
  end

endmodule

// File: rtl/rmw_sequencer.sv
// Read-modify-write sequencer: read, optional NMOS dummy write, modify via external mux, write back, flags.
module rmw_sequencer
  import rmw_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter bit DUMMY_WRITE = 1'b1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              start,
  input  logic [2:0]        rmw_op,
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_ready,
  input  logic [7:0]        compute_result,
  output logic              busy,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic [7:0]        compute_m,
  output logic [4:0]        compute_sel,
  output logic              flag_we,
  output logic              flag_n,
  output logic              flag_z,
  output logic              flag_c,
  output logic              done,
  output logic              err
);

  state_t     state;
  logic [2:0] op_r;
  logic [7:0] result_r;
  logic       carry_r;
  logic       n_calc, z_calc, c_calc;

  rmw_flags u_flags (
    .op      (op_r),
    .operand (compute_m),
    .result  (result_r),
    .n       (n_calc),
    .z       (z_calc),
    .c       (c_calc)
  );

  // Outputs are registered: each transition sets up what the next state drives.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state       <= S_IDLE;
      op_r        <= '0;
      result_r    <= '0;
      carry_r     <= 1'b0;
      busy        <= 1'b0;
      mem_rd      <= 1'b0;
      mem_wr      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      compute_m   <= '0;
      compute_sel <= SEL_PASS_M;
      flag_we     <= 1'b0;
      flag_n      <= 1'b0;
      flag_z      <= 1'b0;
      flag_c      <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      done    <= 1'b0;
      flag_we <= 1'b0;
      err     <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          if (op_legal(rmw_op)) begin
            op_r     <= rmw_op;
            mem_addr <= addr;
            mem_rd   <= 1'b1;
            busy     <= 1'b1;
            state    <= S_RD;
          end else begin
            err <= 1'b1;
          end
        end
        S_RD: if (mem_ready) begin
          compute_m <= mem_rdata;
          mem_rd    <= 1'b0;
          if (DUMMY_WRITE) begin
            mem_wr    <= 1'b1;
            mem_wdata <= mem_rdata;
            state     <= S_DWR;
          end else begin
            compute_sel <= op_to_sel(op_r);
            state       <= S_MOD;
          end
        end
        S_DWR: if (mem_ready) begin
          mem_wr      <= 1'b0;
          compute_sel <= op_to_sel(op_r);
          state       <= S_MOD;
        end
        S_MOD: begin
          result_r    <= compute_result;
          carry_r     <= c_calc;
          compute_sel <= SEL_PASS_M;
          mem_wr      <= 1'b1;
          mem_wdata   <= compute_result;
          state       <= S_WR;
        end
        S_WR: if (mem_ready) begin
          mem_wr  <= 1'b0;
          done    <= 1'b1;
          flag_we <= 1'b1;
          flag_n  <= n_calc;
          flag_z  <= z_calc;
          flag_c  <= carry_r;
          state   <= S_FIN;
        end
        S_FIN: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/rmw_sequencer.md
Name: rmw_sequencer

Overview:
- Sequences the 6502 read-modify-write memory instructions: ASL, LSR, ROL, ROR, INC and DEC on a memory operand.
- Drives the compute mux select, supplies the operand to the mux M-side inputs, performs the memory read, the NMOS dummy write and the final write-back, then reports N/Z/C.
- Sits between the instruction decoder (start/op/addr) and the memory bus. It owns the compute path only while busy.

Parameters:
- ADDR_W, 16, memory address width.
- DUMMY_WRITE, 1, 1 = perform the NMOS-accurate write of the unmodified operand before write-back; 0 = skip that step.

Ports:
- Clk  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- start  in  1  request a read-modify-write operation; sampled only in IDLE.
- rmw_op  in  3  000 ASL, 001 LSR, 010 ROL, 011 ROR, 100 INC, 101 DEC, 110/111 illegal.
- addr  in  ADDR_W  operand address; latched with start.
- mem_rdata  in  8  read data; valid in the cycle mem_ready is high during a read.
- mem_ready  in  1  memory accepts or completes the current access this cycle.
- compute_result  in  8  compute mux Dout.
- busy  out  1  operation in progress.
- mem_rd  out  1  read request; held until mem_ready.
- mem_wr  out  1  write request; held until mem_ready.
- mem_addr  out  ADDR_W  latched address.
- mem_wdata  out  8  write data.
- compute_m  out  8  operand register, wired to the mux M-side inputs.
- compute_sel  out  5  compute mux select.
- flag_we  out  1  one-cycle strobe: update N, Z, C.
- flag_n, flag_z, flag_c  out  1 each  flag values, valid while flag_we is high.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle pulse: illegal rmw_op.

Behaviour:
- Reset (asynchronous, immediate):
  - State goes to IDLE.
  - All outputs and internal registers are 0, except compute_sel = 5'b01101 (PASS_M).
  - Reset mid-operation drops mem_rd/mem_wr in the same instant; no partial write completes after reset.
- States: IDLE, RD, DWR, MOD, WR, FIN.
- IDLE:
  - start=1 with a legal op: latch addr and op, go to RD.
  - start=1 with an illegal op: pulse err next cycle, no memory access, stay IDLE.
  - start=0: stay IDLE.
- RD:
  - mem_rd=1, mem_addr = latched address.
  - On mem_ready: operand reg <= mem_rdata, then go to DWR (DUMMY_WRITE=1) or MOD (DUMMY_WRITE=0).
- DWR:
  - mem_wr=1, mem_wdata = operand, compute_sel = PASS_M (01101).
  - On mem_ready: go to MOD.
- MOD (exactly one cycle):
  - compute_sel from op: ASL 10000, LSR 00110, ROL 01000, ROR 01010, INC 10011, DEC 10110.
  - Result reg <= compute_result.
  - Carry: ASL/ROL C = operand[7]; LSR/ROR C = operand[0]; INC/DEC C unchanged (flag_c driven 0, see FIN).
  - Go to WR.
- WR:
  - mem_wr=1, mem_wdata = result.
  - On mem_ready: go to FIN.
- FIN (one cycle):
  - done=1, flag_we=1, flag_n = result[7], flag_z = (result == 0), flag_c as computed.
  - For INC/DEC, flag_c is not meaningful; the consumer must mask C. A separate flag_c_we is not provided.
  - Go to IDLE.
- Outside MOD and DWR, compute_sel = PASS_M.
- busy=1 in every state except IDLE. start while busy is ignored and not queued.
- mem_rd and mem_wr are never high together. mem_addr is stable from RD through WR.
- Latency with mem_ready tied to 1: start in cycle 0, done in cycle 5 (DUMMY_WRITE=1) or cycle 4 (DUMMY_WRITE=0). Each mem_ready=0 cycle adds one cycle.
- Wrap-around: INC of 0xFF gives 0x00 (Z=1); DEC of 0x00 gives 0xFF (N=1). Width is mod 256; the mux does the arithmetic, the sequencer only registers the result.

Decomposition:
- Package rmw_pkg holds:
  - state enum;
  - rmw_op localparams;
  - 5-bit compute-select constants (SEL_PASS_M, SEL_ASL_M, SEL_LSR_M, SEL_ROL_M, SEL_ROR_M, SEL_INC_M, SEL_DEC_M);
  - function op_to_sel.
- One natural sub-module: rmw_flags (combinational N/Z/C from operand, result and op).

Test Plan:
- ASL, mem_rdata=0x81, mem_ready=1 -> writes 0x81 then 0x02 to addr 0x0200; done at cycle 5; N=0, Z=0, C=1.
- ROR, operand 0x01, DUMMY_WRITE=0 -> single write of 0x00 (mux model, C_in=0); done at cycle 4; Z=1, C=1.
- INC, operand 0xFF, mem_ready low 2 cycles during RD and 1 cycle during WR -> write 0x00; done at cycle 8; Z=1, N=0; mem_rd/mem_wr held through each stall.
- rmw_op=3'b111 -> err pulse 1 cycle; no mem_rd/mem_wr; busy stays 0.
- start re-asserted during WR -> ignored; exactly one done; FSM returns to IDLE.
- Reset asserted mid-DWR -> mem_wr=0 immediately, busy=0, compute_sel=01101, no done; a fresh DEC on operand 0x00 afterwards writes 0xFF with N=1.
